// File: rtl/bottle_pkg.sv
// Purpose: shared state encoding, BCD constants and limit validation for the bottle filler.
// Latency: none (types, constants and a combinational helper only).
// Backpressure: not applicable.
package bottle_pkg;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_WAIT_BOT = 3'd1,
        S_FILL     = 3'd2,
        S_PAUSE    = 3'd3,
        S_SWAP     = 3'd4,
        S_DONE     = 3'd5
    } state_t;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // True when every nibble is a decimal digit and the value is nonzero.
    // Callers zero-extend their limit into the 32-bit argument (up to 8 digits).
    function automatic logic bcd_nonzero_ok(input logic [31:0] v);
        logic ok;
        ok = (v != '0);
        for (int i = 0; i < 8; i++) begin
            if (v[4*i +: 4] > BCD_MAX) begin
                ok = 1'b0;
            end
        end
        return ok;
    endfunction

endpackage

// File: rtl/bcd_counter.sv
// Purpose: multi-digit BCD counter with synchronous clear, increment, and wrap at all-9s.
// Latency: cnt updates on the edge after clr/inc; nxt is the combinational incremented value.
// Backpressure: none; clr wins over inc.
//   CLK, RST : clock, synchronous active-high reset
//   clr, inc : clear to zero / advance by one
//   cnt, nxt : registered count / count+1 (BCD, wrapping)
module bcd_counter
    import bottle_pkg::*;
#(
    parameter int DIGITS = 2
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                clr,
    input  logic                inc,
    output logic [4*DIGITS-1:0] cnt,
    output logic [4*DIGITS-1:0] nxt
);

    logic carry;

    // Ripple carry: a digit at 9 (or any non-decimal value) rolls to 0 and
    // passes the carry on, so the result is always valid BCD.
    always_comb begin
        carry = 1'b1;
        nxt   = '0;
        for (int d = 0; d < DIGITS; d++) begin
            if (carry) begin
                if (cnt[4*d +: 4] >= BCD_MAX) begin
                    nxt[4*d +: 4] = 4'd0;
                end else begin
                    nxt[4*d +: 4] = cnt[4*d +: 4] + 4'd1;
                    carry         = 1'b0;
                end
            end else begin
                nxt[4*d +: 4] = cnt[4*d +: 4];
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST || clr) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= nxt;
        end
    end

endmodule

// File: rtl/bottle_fill_seq.sv
// Purpose: batch sequencer counting pills per bottle and bottles per batch in BCD, with changeover handshake.
// Latency: counts, bot_done and state all update on the edge after the sampled input.
// Backpressure: bot_rdy gates filling; pause freezes; a tick while paused or without a bottle is dropped.
//   CLK, RST                 : clock, synchronous active-high reset
//   start/abort/pause/conti  : panel controls (conti is rising-edge detected)
//   single, pill_tick, bot_rdy : stop-per-bottle mode, pill pulse, bottle present
//   max_pills, max_bots      : BCD limits, latched on an accepted start
//   pill_cnt, bot_cnt        : BCD counts; bot_done, allFull, busy, cfg_err, state : status
module bottle_fill_seq
    import bottle_pkg::*;
#(
    parameter int PILL_DIGITS = 2,
    parameter int BOT_DIGITS  = 2
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     pause,
    input  logic                     conti,
    input  logic                     single,
    input  logic                     pill_tick,
    input  logic                     bot_rdy,
    input  logic [4*PILL_DIGITS-1:0] max_pills,
    input  logic [4*BOT_DIGITS-1:0]  max_bots,
    output logic [4*PILL_DIGITS-1:0] pill_cnt,
    output logic [4*BOT_DIGITS-1:0]  bot_cnt,
    output logic                     bot_done,
    output logic                     allFull,
    output logic                     busy,
    output logic                     cfg_err,
    output logic [2:0]               state
);

    state_t                   st;
    logic [4*PILL_DIGITS-1:0] max_pills_l;
    logic [4*BOT_DIGITS-1:0]  max_bots_l;
    logic [4*PILL_DIGITS-1:0] pill_nxt;
    logic [4*BOT_DIGITS-1:0]  bot_nxt;
    logic                     conti_q;
    logic                     conti_rise;
    logic                     cfg_ok;
    logic                     start_ok;
    logic                     fill_ev;
    logic                     pill_full;
    logic                     batch_restart;

    assign conti_rise = conti && !conti_q;
    assign cfg_ok     = bcd_nonzero_ok(32'(max_pills)) && bcd_nonzero_ok(32'(max_bots));
    assign start_ok   = !abort && (st == S_IDLE) && start && cfg_ok;
    // A tick counts only in FILL with a bottle present and no pause request.
    assign fill_ev    = !abort && (st == S_FILL) && !pause && bot_rdy && pill_tick;
    assign pill_full  = (pill_nxt == max_pills_l);
    // Continuing from a completed quota starts a fresh batch with the same limits.
    assign batch_restart = !abort && (st == S_DONE) && conti_rise && (bot_cnt == max_bots_l);

    bcd_counter #(.DIGITS(PILL_DIGITS)) u_pill_ctr (
        .CLK (CLK),
        .RST (RST),
        .clr (abort || start_ok || (fill_ev && pill_full)),
        .inc (fill_ev && !pill_full),
        .cnt (pill_cnt),
        .nxt (pill_nxt)
    );

    bcd_counter #(.DIGITS(BOT_DIGITS)) u_bot_ctr (
        .CLK (CLK),
        .RST (RST),
        .clr (abort || start_ok || batch_restart),
        .inc (fill_ev && pill_full),
        .cnt (bot_cnt),
        .nxt (bot_nxt)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            st          <= S_IDLE;
            max_pills_l <= '0;
            max_bots_l  <= '0;
            conti_q     <= 1'b0;
            bot_done    <= 1'b0;
            allFull     <= 1'b0;
            cfg_err     <= 1'b0;
        end else begin
            conti_q  <= conti;
            bot_done <= 1'b0;
            cfg_err  <= 1'b0;
            if (abort) begin
                st      <= S_IDLE;
                allFull <= 1'b0;
            end else begin
                case (st)
                    S_IDLE: begin
                        if (start) begin
                            if (cfg_ok) begin
                                max_pills_l <= max_pills;
                                max_bots_l  <= max_bots;
                                st          <= S_WAIT_BOT;
                            end else begin
                                cfg_err <= 1'b1;
                            end
                        end
                    end
                    S_WAIT_BOT: begin
                        if (bot_rdy) st <= S_FILL;
                    end
                    S_FILL: begin
                        if (pause) begin
                            st <= S_PAUSE;
                        end else if (!bot_rdy) begin
                            st <= S_WAIT_BOT;
                        end else if (pill_tick && pill_full) begin
                            bot_done <= 1'b1;
                            if ((bot_nxt == max_bots_l) || single) begin
                                st      <= S_DONE;
                                allFull <= 1'b1;
                            end else begin
                                st <= S_SWAP;
                            end
                        end
                    end
                    S_PAUSE: begin
                        if (!pause) st <= S_FILL;
                    end
                    // Full bottle must leave before the next one is accepted.
                    S_SWAP: begin
                        if (!bot_rdy) st <= S_WAIT_BOT;
                    end
                    S_DONE: begin
                        if (conti_rise) begin
                            allFull <= 1'b0;
                            st      <= S_SWAP;
                        end
                    end
                    default: st <= S_IDLE;
                endcase
            end
        end
    end

    assign busy  = (st != S_IDLE);
    assign state = st;

endmodule

// File: tb/tb_bottle_fill_seq.sv
module tb_bottle_fill_seq;

    logic       CLK = 1'b0;
    logic       RST, start, abort, pause, conti, single, pill_tick, bot_rdy;
    logic [7:0] max_pills, max_bots;
    logic [7:0] pill_cnt, bot_cnt;
    logic       bot_done, allFull, busy, cfg_err;
    logic [2:0] state;

    int checks = 0;
    int errors = 0;

    // Reference model: plain integers for counts, state numbers as listed.
    int  m_st, m_pc, m_bc, m_mp, m_mb;
    bit  m_full, m_done, m_cerr, m_cq;

    always #5 CLK = ~CLK;

    bottle_fill_seq dut (
        .CLK(CLK), .RST(RST), .start(start), .abort(abort), .pause(pause),
        .conti(conti), .single(single), .pill_tick(pill_tick), .bot_rdy(bot_rdy),
        .max_pills(max_pills), .max_bots(max_bots), .pill_cnt(pill_cnt),
        .bot_cnt(bot_cnt), .bot_done(bot_done), .allFull(allFull), .busy(busy),
        .cfg_err(cfg_err), .state(state)
    );

    function automatic logic [7:0] to_bcd(int v);
        return {4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    function automatic bit lim_ok(logic [7:0] v);
        return (v[7:4] <= 4'd9) && (v[3:0] <= 4'd9) && (v != 8'h00);
    endfunction

    function automatic int bcd_val(logic [7:0] v);
        return int'(v[7:4]) * 10 + int'(v[3:0]);
    endfunction

    function automatic void model_step();
        bit rise;
        rise   = conti && !m_cq;
        m_done = 0;
        m_cerr = 0;
        if (RST) begin
            m_st = 0; m_pc = 0; m_bc = 0; m_mp = 0; m_mb = 0; m_full = 0; m_cq = 0;
            return;
        end
        m_cq = conti;
        if (abort) begin
            m_st = 0; m_pc = 0; m_bc = 0; m_full = 0;
            return;
        end
        case (m_st)
            0: if (start) begin
                if (lim_ok(max_pills) && lim_ok(max_bots)) begin
                    m_mp = bcd_val(max_pills); m_mb = bcd_val(max_bots);
                    m_pc = 0; m_bc = 0; m_st = 1;
                end else m_cerr = 1;
            end
            1: if (bot_rdy) m_st = 2;
            2: if (pause) m_st = 3;
               else if (!bot_rdy) m_st = 1;
               else if (pill_tick) begin
                   if (m_pc + 1 == m_mp) begin
                       m_pc = 0; m_bc = (m_bc + 1) % 100; m_done = 1;
                       if (m_bc == m_mb || single) begin m_st = 5; m_full = 1; end
                       else m_st = 4;
                   end else m_pc = m_pc + 1;
               end
            3: if (!pause) m_st = 2;
            4: if (!bot_rdy) m_st = 1;
            5: if (rise) begin
                   m_full = 0;
                   if (m_bc == m_mb) m_bc = 0;
                   m_st = 4;
               end
            default: m_st = 0;
        endcase
    endfunction

    // One clock: model consumes the same inputs the DUT samples; outputs settle by #1.
    task automatic cycle();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic clr_in();
        start = 0; abort = 0; pause = 0; conti = 0; single = 0; pill_tick = 0; bot_rdy = 0;
    endtask

    task automatic begin_batch(input logic [7:0] mp, input logic [7:0] mb);
        max_pills = mp; max_bots = mb; start = 1;
        cycle();
        start = 0;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            pill_tick = 1; cycle(); pill_tick = 0;
        end
    endtask

    task automatic end_batch();
        abort = 1; cycle(); abort = 0; clr_in();
    endtask

    task automatic test_reset();
        clr_in(); max_pills = 8'h00; max_bots = 8'h00; RST = 1;
        cycle(); cycle();
        RST = 0;
        checks++;
        if ({pill_cnt, bot_cnt, bot_done, allFull, busy, cfg_err, state} !== 23'h0) begin
            errors++;
            $display("FAIL reset outs pill=%h bot=%h done=%b full=%b busy=%b cerr=%b st=%0d, expected all 0",
                     pill_cnt, bot_cnt, bot_done, allFull, busy, cfg_err, state);
        end
    endtask

    task automatic test_basic();
        begin_batch(8'h03, 8'h02);
        checks++; if (state !== 3'd1 || busy !== 1'b1) begin errors++; $display("FAIL basic start st=%0d busy=%b exp 1/1", state, busy); end
        bot_rdy = 1; cycle();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL basic fill st=%0d exp 2", state); end
        for (int b = 0; b < 2; b++) begin
            for (int t = 1; t <= 3; t++) begin
                pill_tick = 1; cycle(); pill_tick = 0;
                checks++; if (bot_done !== (t == 3)) begin errors++; $display("FAIL basic bot_done b=%0d t=%0d got %b", b, t, bot_done); end
                checks++; if (pill_cnt !== to_bcd(t % 3)) begin errors++; $display("FAIL basic pill_cnt got %h exp %h", pill_cnt, to_bcd(t % 3)); end
            end
            checks++; if (bot_cnt !== to_bcd(b + 1)) begin errors++; $display("FAIL basic bot_cnt got %h exp %h", bot_cnt, to_bcd(b + 1)); end
            if (b == 0) begin
                checks++; if (state !== 3'd4) begin errors++; $display("FAIL basic swap st=%0d exp 4", state); end
                bot_rdy = 0; cycle(); bot_rdy = 1; cycle();
                checks++; if (state !== 3'd2) begin errors++; $display("FAIL basic refill st=%0d exp 2", state); end
            end
        end
        checks++; if (state !== 3'd5 || allFull !== 1'b1) begin errors++; $display("FAIL basic done st=%0d full=%b exp 5/1", state, allFull); end
        conti = 1; cycle();
        checks++; if (bot_cnt !== 8'h00 || allFull !== 1'b0 || state !== 3'd4) begin
            errors++; $display("FAIL basic conti bot=%h full=%b st=%0d exp 00/0/4", bot_cnt, allFull, state); end
        end_batch();
    endtask

    task automatic test_bcd_carry();
        begin_batch(8'h12, 8'h05);
        bot_rdy = 1; cycle();
        for (int t = 1; t <= 12; t++) begin
            pill_tick = 1; cycle(); pill_tick = 0;
            checks++; if (pill_cnt !== ((t == 12) ? 8'h00 : to_bcd(t))) begin
                errors++; $display("FAIL carry pill_cnt t=%0d got %h", t, pill_cnt); end
            checks++; if (bot_done !== (t == 12)) begin errors++; $display("FAIL carry bot_done t=%0d got %b", t, bot_done); end
        end
        end_batch();
    endtask

    task automatic test_pause();
        begin_batch(8'h09, 8'h02);
        bot_rdy = 1; cycle();
        ticks(4);
        pause = 1; pill_tick = 1; cycle(); pill_tick = 0;
        checks++; if (pill_cnt !== 8'h04 || state !== 3'd3) begin errors++; $display("FAIL pause hold pill=%h st=%0d exp 04/3", pill_cnt, state); end
        ticks(2);
        checks++; if (pill_cnt !== 8'h04) begin errors++; $display("FAIL pause ignore pill=%h exp 04", pill_cnt); end
        pause = 0; cycle();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL pause resume st=%0d exp 2", state); end
        ticks(1);
        checks++; if (pill_cnt !== 8'h05) begin errors++; $display("FAIL pause tick pill=%h exp 05", pill_cnt); end
        end_batch();
    endtask

    task automatic test_single();
        begin_batch(8'h02, 8'h05);
        single = 1; bot_rdy = 1; cycle();
        ticks(2);
        checks++; if (state !== 3'd5 || allFull !== 1'b1 || bot_cnt !== 8'h01) begin
            errors++; $display("FAIL single done st=%0d full=%b bot=%h exp 5/1/01", state, allFull, bot_cnt); end
        conti = 1; cycle(); conti = 0;
        checks++; if (state !== 3'd4 || allFull !== 1'b0 || bot_cnt !== 8'h01) begin
            errors++; $display("FAIL single conti st=%0d full=%b bot=%h exp 4/0/01", state, allFull, bot_cnt); end
        bot_rdy = 0; cycle(); bot_rdy = 1; cycle();
        checks++; if (state !== 3'd2) begin errors++; $display("FAIL single refill st=%0d exp 2", state); end
        end_batch();
    endtask

    task automatic test_cfg_err();
        logic [15:0] bad [3];
        bad[0] = 16'h0005; bad[1] = 16'h051A; bad[2] = 16'hA101;
        for (int i = 0; i < 3; i++) begin
            max_pills = bad[i][15:8]; max_bots = bad[i][7:0]; start = 1;
            cycle(); start = 0;
            checks++; if (cfg_err !== 1'b1 || state !== 3'd0 || busy !== 1'b0) begin
                errors++; $display("FAIL cfg_err case %0d cerr=%b st=%0d busy=%b exp 1/0/0", i, cfg_err, state, busy); end
            cycle();
            checks++; if (cfg_err !== 1'b0) begin errors++; $display("FAIL cfg_err pulse case %0d cerr=%b exp 0", i, cfg_err); end
        end
    endtask

    task automatic test_abort_rst();
        begin_batch(8'h08, 8'h05);
        bot_rdy = 1; cycle();
        for (int b = 0; b < 3; b++) begin
            ticks(8); bot_rdy = 0; cycle(); bot_rdy = 1; cycle();
        end
        ticks(7);
        checks++; if (pill_cnt !== 8'h07 || bot_cnt !== 8'h03) begin errors++; $display("FAIL abort setup pill=%h bot=%h exp 07/03", pill_cnt, bot_cnt); end
        abort = 1; cycle(); abort = 0;
        checks++; if (state !== 3'd0 || pill_cnt !== 8'h00 || bot_cnt !== 8'h00) begin
            errors++; $display("FAIL abort st=%0d pill=%h bot=%h exp 0/00/00", state, pill_cnt, bot_cnt); end
        begin_batch(8'h05, 8'h02);
        ticks(1); ticks(2); pause = 1; cycle();
        RST = 1; cycle(); RST = 0; clr_in();
        checks++; if ({pill_cnt, bot_cnt, bot_done, allFull, busy, cfg_err, state} !== 23'h0) begin
            errors++; $display("FAIL rst mid-pause pill=%h bot=%h st=%0d busy=%b exp all 0", pill_cnt, bot_cnt, state, busy); end
    endtask

    task automatic test_random();
        for (int n = 0; n < 4000; n++) begin
            RST       = ($urandom_range(0, 499) == 0);
            abort     = ($urandom_range(0, 249) == 0);
            start     = ($urandom_range(0, 5) == 0);
            conti     = ($urandom_range(0, 3) == 0);
            single    = ($urandom_range(0, 3) == 0);
            pill_tick = ($urandom_range(0, 1) == 0);
            if ($urandom_range(0, 3) == 0) bot_rdy = ~bot_rdy;
            if ($urandom_range(0, 9) == 0) pause = ~pause;
            max_pills = ($urandom_range(0, 9) == 0) ? 8'h0B : to_bcd($urandom_range(1, 12));
            max_bots  = ($urandom_range(0, 9) == 0) ? 8'h00 : to_bcd($urandom_range(1, 4));
            cycle();
            checks++; if (pill_cnt !== to_bcd(m_pc)) begin errors++; $display("FAIL rand pill_cnt n=%0d got %h exp %h", n, pill_cnt, to_bcd(m_pc)); end
            checks++; if (bot_cnt !== to_bcd(m_bc)) begin errors++; $display("FAIL rand bot_cnt n=%0d got %h exp %h", n, bot_cnt, to_bcd(m_bc)); end
            checks++; if (state !== 3'(m_st) || busy !== (m_st != 0)) begin errors++; $display("FAIL rand state n=%0d got %0d/%b exp %0d", n, state, busy, m_st); end
            checks++; if ({bot_done, allFull, cfg_err} !== {m_done, m_full, m_cerr}) begin
                errors++; $display("FAIL rand flags n=%0d got done=%b full=%b cerr=%b exp %b%b%b", n, bot_done, allFull, cfg_err, m_done, m_full, m_cerr); end
        end
    endtask

    initial begin
        RST = 1; clr_in(); max_pills = 8'h00; max_bots = 8'h00;
        m_st = 0; m_pc = 0; m_bc = 0; m_mp = 0; m_mb = 0;
        m_full = 0; m_done = 0; m_cerr = 0; m_cq = 0;
        test_reset();
        test_basic();
        test_bcd_carry();
        test_pause();
        test_single();
        test_cfg_err();
        test_abort_rst();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bottle_fill_seq.md
Name: bottle_fill_seq

Overview:
- Parametrised successor to the single-line pill/bottle counter.
- Counts pill detector pulses in BCD into the current bottle and counts filled bottles in BCD against a batch quota.
- Sequences bottle changeover with a bottle-present handshake. Supports pause/resume, single-bottle mode, continue-after-full and abort.
- Sits between the pill sensor/conveyor interface and the display/panel logic.

Parameters:
- PILL_DIGITS, 2, BCD digits of per-bottle pill count and limit.
- BOT_DIGITS, 2, BCD digits of bottle count and batch quota.

Ports:
- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- start  in  1  level; begins a batch from IDLE.
- abort  in  1  level; returns to IDLE and clears counts.
- pause  in  1  level; freezes filling.
- conti  in  1  continue request, rising-edge detected internally.
- single  in  1  1 = stop after each bottle (sampled at each bottle completion).
- pill_tick  in  1  one-cycle pulse per pill dropped.
- bot_rdy  in  1  level; empty bottle in position.
- max_pills  in  4*PILL_DIGITS  BCD pills per bottle, latched on start.
- max_bots  in  4*BOT_DIGITS  BCD bottles per batch, latched on start.
- pill_cnt  out  4*PILL_DIGITS  BCD pills in current bottle (registered).
- bot_cnt  out  4*BOT_DIGITS  BCD bottles completed (registered).
- bot_done  out  1  one-cycle pulse when a bottle reaches max_pills.
- allFull  out  1  batch quota reached, or single-mode stop.
- busy  out  1  state is not IDLE.
- cfg_err  out  1  one-cycle pulse when start is rejected.
- state  out  3  current FSM state code.

Behaviour:
- Reset values: all outputs 0, state IDLE, latched limits 0, conti edge register 0.
- Priority per cycle: RST > abort > state logic.
- abort in any state: next state IDLE; pill_cnt and bot_cnt cleared; allFull cleared.
- States: IDLE=0, WAIT_BOT=1, FILL=2, PAUSE=3, SWAP=4, DONE=5.
- IDLE + start:
  - If either limit is all-zero or any nibble > 9: pulse cfg_err, stay in IDLE.
  - Otherwise: latch both limits, clear both counts, go to WAIT_BOT.
  - start in any other state is ignored.
- WAIT_BOT: bot_rdy=1 -> FILL next cycle. pill_tick is ignored.
- FILL:
  - pause=1 -> PAUSE. pause has priority over a same-cycle pill_tick; that tick is dropped.
  - bot_rdy=0 -> WAIT_BOT, pill_cnt held (bottle removed mid-fill).
  - On pill_tick, if pill_cnt+1 == max_pills:
    - pill_cnt <= 0, bot_cnt <= bot_cnt+1 (BCD), bot_done pulses the same cycle.
    - Then, first match wins: new bot_cnt == max_bots -> DONE with allFull=1; else single=1 -> DONE with allFull=1; else -> SWAP.
  - Otherwise pill_tick increments pill_cnt in BCD, with carry from digit 9 to the next digit.
- PAUSE: pause=0 -> FILL. Counts held, ticks ignored.
- SWAP: wait for bot_rdy=0 (full bottle removed), then go to WAIT_BOT. This is a two-step handshake, so the same bottle is never refilled.
- DONE:
  - Counts held.
  - conti rising edge: clear allFull. If bot_cnt == max_bots, clear bot_cnt (new batch with the same latched limits). Go to SWAP.
  - conti held high does not retrigger.
- BCD wrap: bot_cnt at all-9s wraps to 0. This is unreachable with a valid quota but must not produce an X or a non-BCD value.
- Latency: count outputs update on the clock edge following the tick. bot_done and the state change occur on the same edge.
- The limit inputs may change freely after start; only the latched copies are used.

Decomposition:
- Package bottle_pkg:
  - State encoding constants.
  - Nibble constant BCD_MAX=9.
  - Function checking that a vector is valid BCD and nonzero.
- Sub-module bcd_counter:
  - Parameter DIGITS.
  - Inputs clr and inc; output cnt.
  - Ripple-carry BCD increment with wrap.
- bcd_counter is instantiated twice: pills and bottles.

Test Plan:
1. max_pills=03, max_bots=02, single=0, bot_rdy toggled per bottle, 6 ticks -> bot_done at ticks 3 and 6; bot_cnt 01 then 02; allFull=1; state DONE; pill_cnt 00.
2. max_pills=12, 11 ticks -> pill_cnt 09 then 10 then 11 (BCD carry). Tick 12 -> bot_done, pill_cnt 00.
3. pause asserted in FILL on the same cycle as pill_tick with pill_cnt=04 -> pill_cnt stays 04, state PAUSE. Release pause, one tick -> 05.
4. single=1, max_pills=02, max_bots=05: fill one bottle -> DONE, allFull=1, bot_cnt 01. conti pulse -> allFull=0, SWAP. bot_rdy low then high -> FILL.
5. start with max_pills=00 or max_bots=1A -> cfg_err one cycle, state IDLE, busy=0.
6. abort mid-FILL with pill_cnt=07, bot_cnt=03 -> next cycle IDLE, counts 00. RST mid-PAUSE -> all outputs 0 on the next edge.
